// File: rtl/dv_apb_target_mem.sv
// dv_apb_target_mem: simulation APB completer with a word-addressed memory,
// programmable wait states, error injection, sticky protocol-violation flag
// and completed-transfer counters.
module dv_apb_target_mem #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int DEPTH          = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      pclk_i,
  input  logic                      prst_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
  input  logic                      pwrite_i,
  input  logic [APB_DATA_WIDTH-1:0] pwdata_i,
  output logic [APB_DATA_WIDTH-1:0] prdata_o,
  output logic                      pready_o,
  output logic                      psuberr_o,
  input  logic [3:0]                wait_cycles_i,
  input  logic                      err_inject_i,
  output logic                      proto_err_o,
  output logic [CNT_WIDTH-1:0]      wr_count_o,
  output logic [CNT_WIDTH-1:0]      rd_count_o
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  logic [0:0]                r_state;
  logic [APB_ADDR_WIDTH-1:0] r_addr;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_write;
  logic [APB_DATA_WIDTH-1:0] r_wdata;
  logic                      r_err;
  logic [3:0]                r_wait_cnt;
  logic                      r_pready;
  logic                      r_psuberr;
  logic [APB_DATA_WIDTH-1:0] r_prdata;
  logic                      r_proto_err;
  logic [CNT_WIDTH-1:0]      r_wr_count;
  logic [CNT_WIDTH-1:0]      r_rd_count;
  logic [APB_DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                      w_setup;
  logic                      w_enable;
  logic [IDX_W-1:0]          w_idx;
  logic                      w_setup_err;
  logic [APB_DATA_WIDTH-1:0] w_setup_rdata;
  logic [APB_DATA_WIDTH-1:0] w_wait_rdata;
  logic                      w_complete;
  logic                      w_commit;
  logic                      w_changed;

  // Decode of the setup phase and of the latched transfer; only the low
  // 12 address bits select a word, the full address is kept so any change
  // during the access phase can be spotted.
  always_comb begin
    w_setup       = psel_i & ~penable_i;
    w_enable      = psel_i & penable_i;
    w_idx         = paddr_i[IDX_W+1:2];
    w_setup_err   = (paddr_i[1:0] != 2'b00) |
                    ({1'b0, paddr_i[11:2]} >= DEPTH_L) |
                    err_inject_i;
    w_setup_rdata = (!pwrite_i && !w_setup_err) ? r_mem[w_idx] : '0;
    w_wait_rdata  = (!r_write && !r_err) ? r_mem[r_idx] : '0;
    w_complete    = (r_state == ST_ACCESS) & w_enable & r_pready;
    w_commit      = w_complete & r_write & ~r_err;
    w_changed     = (r_state == ST_ACCESS) & psel_i &
                    ((paddr_i != r_addr) | (pwrite_i != r_write));
  end

  // Transfer FSM: latches the request at setup, counts wait states, and
  // presents registered response data on the edge pready rises.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_wait_cnt  <= 4'd0;
      r_pready    <= 1'b0;
      r_psuberr   <= 1'b0;
      r_prdata    <= '0;
      r_proto_err <= 1'b0;
      r_wr_count  <= '0;
      r_rd_count  <= '0;
    end else begin
      if (w_changed) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_setup) begin
            r_state    <= ST_ACCESS;
            r_addr     <= paddr_i;
            r_idx      <= w_idx;
            r_write    <= pwrite_i;
            r_wdata    <= pwdata_i;
            r_err      <= w_setup_err;
            r_wait_cnt <= wait_cycles_i;
            if (wait_cycles_i == 4'd0) begin
              r_pready  <= 1'b1;
              r_prdata  <= w_setup_rdata;
              r_psuberr <= w_setup_err;
            end
          end else if (w_enable) begin
            r_proto_err <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!psel_i) begin
            r_state     <= ST_IDLE;
            r_pready    <= 1'b0;
            r_psuberr   <= 1'b0;
            r_prdata    <= '0;
            r_proto_err <= 1'b1;
          end else if (penable_i) begin
            if (r_pready) begin
              r_state   <= ST_IDLE;
              r_pready  <= 1'b0;
              r_psuberr <= 1'b0;
              r_prdata  <= '0;
              if (!r_err) begin
                if (r_write) begin
                  r_wr_count <= r_wr_count + CNT_ONE;
                end else begin
                  r_rd_count <= r_rd_count + CNT_ONE;
                end
              end
            end else begin
              r_wait_cnt <= r_wait_cnt - 4'd1;
              if (r_wait_cnt == 4'd1) begin
                r_pready  <= 1'b1;
                r_prdata  <= w_wait_rdata;
                r_psuberr <= r_err;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Word storage: cleared by reset, written only when a non-error write completes.
  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign prdata_o    = r_prdata;
  assign pready_o    = r_pready;
  assign psuberr_o   = r_psuberr;
  assign proto_err_o = r_proto_err;
  assign wr_count_o  = r_wr_count;
  assign rd_count_o  = r_rd_count;

endmodule

// File: tb/tb_dv_apb_target_mem.sv
// tb_dv_apb_target_mem: randomized and directed bench for dv_apb_target_mem,
// checked against a word-array reference model of the memory and counters.
module tb_dv_apb_target_mem;

  localparam int DEPTH = 64;

  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        psuberr;
  logic [3:0]  waitCycles = 4'd0;
  logic        errInject = 1'b0;
  logic        protoErr;
  logic [15:0] wrCount;
  logic [15:0] rdCount;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] modelMem [DEPTH];
  int          modelWr;
  int          modelRd;
  logic        modelProto;

  dv_apb_target_mem #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(16)
  ) dut (
    .pclk_i(pclk), .prst_i(prst), .psel_i(psel), .penable_i(penable),
    .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .psuberr_o(psuberr), .wait_cycles_i(waitCycles),
    .err_inject_i(errInject), .proto_err_o(protoErr),
    .wr_count_o(wrCount), .rd_count_o(rdCount)
  );

  // Free-running bus clock.
  always #5 pclk = ~pclk;

  // Reference model: one APB transfer judged from the address rules alone.
  task automatic modelAccess(input logic [31:0] a, input logic w, input logic [31:0] d,
                             input logic inj, output logic expErr, output logic [31:0] expRd);
    int a12;
    a12    = int'(a & 32'hFFF);
    expErr = ((a12 % 4) != 0) || ((a12 / 4) >= DEPTH) || inj;
    expRd  = '0;
    if (!expErr) begin
      if (w) begin
        modelMem[a12 / 4] = d;
        modelWr = (modelWr + 1) % 65536;
      end else begin
        expRd = modelMem[a12 / 4];
        modelRd = (modelRd + 1) % 65536;
      end
    end
  endtask

  // Reset the DUT and the model; returns at posedge+1 with the bus idle.
  task automatic doReset();
    psel = 1'b0; penable = 1'b0; errInject = 1'b0; waitCycles = 4'd0;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0;
    for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
    modelWr = 0; modelRd = 0; modelProto = 1'b0;
  endtask

  // One full APB transfer; cyc is the number of access cycles (0 on timeout).
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] wc, input logic inj,
                      output logic [31:0] rd, output logic er, output int cyc);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    waitCycles = wc; errInject = inj;
    @(posedge pclk); #1;
    penable = 1'b1; errInject = 1'b0; waitCycles = 4'd0;
    cyc = 0; rd = '0; er = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (pready === 1'b1) begin
        cyc = n; rd = prdata; er = psuberr;
        break;
      end
      @(posedge pclk); #1;
    end
    if (cyc != 0) begin
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    nChecks++; if (prdata !== 32'h0)  begin nFail++; $display("[TB] FAIL reset_prdata got %h expected 0", prdata); end
    nChecks++; if (pready !== 1'b0)   begin nFail++; $display("[TB] FAIL reset_pready got %b expected 0", pready); end
    nChecks++; if (psuberr !== 1'b0)  begin nFail++; $display("[TB] FAIL reset_psuberr got %b expected 0", psuberr); end
    nChecks++; if (protoErr !== 1'b0) begin nFail++; $display("[TB] FAIL reset_proto got %b expected 0", protoErr); end
    nChecks++; if (wrCount !== 16'd0) begin nFail++; $display("[TB] FAIL reset_wrcount got %0d expected 0", wrCount); end
    nChecks++; if (rdCount !== 16'd0) begin nFail++; $display("[TB] FAIL reset_rdcount got %0d expected 0", rdCount); end
  endtask

  task automatic test_basic_rw();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    doReset();
    modelAccess(32'h010, 1'b1, 32'hDEADBEEF, 1'b0, expErr, expRd);
    xfer(32'h010, 1'b1, 32'hDEADBEEF, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (cyc != 1)     begin nFail++; $display("[TB] FAIL basic_wr_cycles got %0d expected 1", cyc); end
    nChecks++; if (er !== 1'b0)  begin nFail++; $display("[TB] FAIL basic_wr_err got %b expected 0", er); end
    nChecks++; if (pready !== 1'b0) begin nFail++; $display("[TB] FAIL basic_pready_drop got %b expected 0", pready); end
    modelAccess(32'h010, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h010, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (cyc != 1)      begin nFail++; $display("[TB] FAIL basic_rd_cycles got %0d expected 1", cyc); end
    nChecks++; if (rd !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL basic_rd_data got %h expected deadbeef", rd); end
    nChecks++; if (er !== expErr) begin nFail++; $display("[TB] FAIL basic_rd_err got %b expected %b", er, expErr); end
    nChecks++; if (wrCount !== 16'(modelWr)) begin nFail++; $display("[TB] FAIL basic_wrcount got %0d expected %0d", wrCount, modelWr); end
    nChecks++; if (rdCount !== 16'(modelRd)) begin nFail++; $display("[TB] FAIL basic_rdcount got %0d expected %0d", rdCount, modelRd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    doReset();
    modelAccess(32'h000, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h000, 1'b0, 32'h0, 4'd3, 1'b0, rd, er, cyc);
    nChecks++; if (cyc != 4)      begin nFail++; $display("[TB] FAIL wait3_cycles got %0d expected 4", cyc); end
    nChecks++; if (rd !== expRd)  begin nFail++; $display("[TB] FAIL wait3_data got %h expected %h", rd, expRd); end
    nChecks++; if (er !== expErr) begin nFail++; $display("[TB] FAIL wait3_err got %b expected %b", er, expErr); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    doReset();
    modelAccess(32'h000, 1'b1, 32'h11111111, 1'b0, expErr, expRd);
    xfer(32'h000, 1'b1, 32'h11111111, 4'd0, 1'b0, rd, er, cyc);
    modelAccess(32'h002, 1'b1, 32'h22222222, 1'b0, expErr, expRd);
    xfer(32'h002, 1'b1, 32'h22222222, 4'd1, 1'b0, rd, er, cyc);
    nChecks++; if (er !== expErr || cyc != 2) begin nFail++; $display("[TB] FAIL unaligned_err got err=%b cyc=%0d expected err=%b cyc=2", er, cyc, expErr); end
    modelAccess(32'h100, 1'b1, 32'h33333333, 1'b0, expErr, expRd);
    xfer(32'h100, 1'b1, 32'h33333333, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (er !== expErr) begin nFail++; $display("[TB] FAIL range_err got %b expected %b", er, expErr); end
    nChecks++; if (wrCount !== 16'(modelWr)) begin nFail++; $display("[TB] FAIL err_wrcount got %0d expected %0d", wrCount, modelWr); end
    nChecks++; if (rdCount !== 16'(modelRd)) begin nFail++; $display("[TB] FAIL err_rdcount got %0d expected %0d", rdCount, modelRd); end
    modelAccess(32'h000, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h000, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd) begin nFail++; $display("[TB] FAIL err_word0 got %h expected %h", rd, expRd); end
  endtask

  task automatic test_err_inject();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    modelAccess(32'h004, 1'b1, 32'h1234, 1'b1, expErr, expRd);
    xfer(32'h004, 1'b1, 32'h1234, 4'd0, 1'b1, rd, er, cyc);
    nChecks++; if (er !== expErr) begin nFail++; $display("[TB] FAIL inject_err got %b expected %b", er, expErr); end
    nChecks++; if (wrCount !== 16'(modelWr)) begin nFail++; $display("[TB] FAIL inject_wrcount got %0d expected %0d", wrCount, modelWr); end
    modelAccess(32'h004, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h004, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd || er !== expErr) begin nFail++; $display("[TB] FAIL inject_readback got %h/%b expected %h/%b", rd, er, expRd, expErr); end
  endtask

  task automatic test_abort();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    psel = 1'b1; penable = 1'b0; paddr = 32'h008; pwrite = 1'b1; pwdata = 32'hCAFEF00D; waitCycles = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    modelProto = 1'b1;
    nChecks++; if (protoErr !== modelProto) begin nFail++; $display("[TB] FAIL abort_proto got %b expected %b", protoErr, modelProto); end
    nChecks++; if (pready !== 1'b0) begin nFail++; $display("[TB] FAIL abort_pready got %b expected 0", pready); end
    nChecks++; if (wrCount !== 16'(modelWr)) begin nFail++; $display("[TB] FAIL abort_wrcount got %0d expected %0d", wrCount, modelWr); end
    modelAccess(32'h008, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h008, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd || cyc != 1) begin nFail++; $display("[TB] FAIL abort_readback got %h cyc=%0d expected %h cyc=1", rd, cyc, expRd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    psel = 1'b1; penable = 1'b0; paddr = 32'h00C; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; waitCycles = 4'd6;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #2;
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    #1;
    nChecks++; if ({prdata, pready, psuberr, protoErr} !== 35'd0) begin nFail++; $display("[TB] FAIL midreset_outputs got %h/%b/%b/%b expected 0", prdata, pready, psuberr, protoErr); end
    nChecks++; if ({wrCount, rdCount} !== 32'd0) begin nFail++; $display("[TB] FAIL midreset_counts got %0d/%0d expected 0/0", wrCount, rdCount); end
    doReset();
    modelAccess(32'h00C, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h00C, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd) begin nFail++; $display("[TB] FAIL midreset_readback got %h expected %h", rd, expRd); end
  endtask

  task automatic test_proto();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    doReset();
    psel = 1'b1; penable = 1'b1; paddr = 32'h0; pwrite = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    nChecks++; if (protoErr !== 1'b1) begin nFail++; $display("[TB] FAIL noset_proto got %b expected 1", protoErr); end
    nChecks++; if (pready !== 1'b0 || rdCount !== 16'd0) begin nFail++; $display("[TB] FAIL noset_response got %b/%0d expected 0/0", pready, rdCount); end
    doReset();
    modelAccess(32'h014, 1'b1, 32'h55, 1'b0, expErr, expRd);
    psel = 1'b1; penable = 1'b0; paddr = 32'h014; pwrite = 1'b1; pwdata = 32'h55; waitCycles = 4'd2;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = 32'h018;
    cyc = 0;
    for (int n = 1; n <= 20; n++) begin
      if (pready === 1'b1) begin cyc = n; break; end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    nChecks++; if (protoErr !== 1'b1 || cyc != 3) begin nFail++; $display("[TB] FAIL addrchg_proto got %b cyc=%0d expected 1 cyc=3", protoErr, cyc); end
    modelAccess(32'h014, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h014, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd) begin nFail++; $display("[TB] FAIL addrchg_latched got %h expected %h", rd, expRd); end
    modelAccess(32'h018, 1'b0, 32'h0, 1'b0, expErr, expRd);
    xfer(32'h018, 1'b0, 32'h0, 4'd0, 1'b0, rd, er, cyc);
    nChecks++; if (rd !== expRd) begin nFail++; $display("[TB] FAIL addrchg_other got %h expected %h", rd, expRd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, expRd; logic er, expErr; int cyc;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, d;
      a = 32'(i * 4 + 32);
      d = $urandom;
      modelAccess(a, (i < 2), d, 1'b0, expErr, expRd);
      xfer(a, (i < 2), d, 4'd0, 1'b0, rd, er, cyc);
      nChecks++; if (rd !== expRd || er !== expErr || cyc != 1) begin nFail++; $display("[TB] FAIL b2b_%0d got %h/%b/%0d expected %h/%b/1", i, rd, er, cyc, expRd, expErr); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, expRd, a, d; logic er, expErr, w, inj; logic [3:0] wc; int cyc, sel;
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (sel == 1) a = 32'($urandom_range(64, 1023) * 4);
      else               a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F000);
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      wc  = 4'($urandom_range(0, 3));
      inj = ($urandom_range(0, 7) == 0);
      modelAccess(a, w, d, inj, expErr, expRd);
      xfer(a, w, d, wc, inj, rd, er, cyc);
      nChecks++; if (cyc != int'(wc) + 1) begin nFail++; $display("[TB] FAIL rand%0d_cycles got %0d expected %0d", i, cyc, int'(wc) + 1); end
      nChecks++; if (rd !== expRd) begin nFail++; $display("[TB] FAIL rand%0d_data addr=%h got %h expected %h", i, a, rd, expRd); end
      nChecks++; if (er !== expErr) begin nFail++; $display("[TB] FAIL rand%0d_err addr=%h got %b expected %b", i, a, er, expErr); end
    end
    nChecks++; if (wrCount !== 16'(modelWr)) begin nFail++; $display("[TB] FAIL rand_wrcount got %0d expected %0d", wrCount, modelWr); end
    nChecks++; if (rdCount !== 16'(modelRd)) begin nFail++; $display("[TB] FAIL rand_rdcount got %0d expected %0d", rdCount, modelRd); end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    $display("[TB] starting dv_apb_target_mem bench");
    #1;
    test_reset();
    test_basic_rw();
    test_wait_states();
    test_errors();
    test_err_inject();
    test_abort();
    test_reset_mid();
    test_proto();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
